// File: rtl/control_fsm_pkg.sv
// Shared types and constants for the multi-cycle control FSM: opcodes, state encoding,
// immediate-format selectors and the DECODE dispatch helper.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StAluWb,
        StBranch,
        StTrap
    } state_e;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_M = 2'b01;
    localparam logic [1:0] IMM_R = 2'b10;

    localparam logic [3:0] OP_R_LAST = 4'b0110;
    localparam logic [3:0] OP_I_LO   = 4'b0111;
    localparam logic [3:0] OP_I_HI   = 4'b1000;
    localparam logic [3:0] OP_LOAD   = 4'b1001;
    localparam logic [3:0] OP_STORE  = 4'b1010;
    localparam logic [3:0] OP_CMP    = 4'b1011;
    localparam logic [3:0] OP_BEQ    = 4'b1100;
    localparam logic [3:0] OP_BNE    = 4'b1101;

    // StFetch doubles as the "undefined opcode" marker for the caller.
    function automatic state_e op_target(logic [3:0] op);
        if (op <= OP_R_LAST) return StExecR;
        if (op inside {OP_I_LO, OP_I_HI}) return StExecI;
        if (op inside {OP_LOAD, OP_STORE}) return StMemAddr;
        if (op inside {OP_CMP, OP_BEQ, OP_BNE}) return StBranch;
        return StFetch;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction/memory handshake bundle between the datapath (master) and the control FSM (slave).
interface control_fsm_if #(
    parameter int unsigned OP_W = 4
);
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            stall;
    logic            pc_write;
    logic            ir_write;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            result_src;
    logic [1:0]      imm_src;
    logic            branch;
    logic            mem_err;
    logic            illegal;

    modport master (
        output op, mem_ready, stall,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, result_src,
        input  imm_src, branch, mem_err, illegal
    );

    modport slave (
        input  op, mem_ready, stall,
        output pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, result_src,
        output imm_src, branch, mem_err, illegal
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter; expired is high once TIMEOUT un-acknowledged wait cycles have elapsed.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT));
endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM. Define CONTROL_FSM_TRAP_EN to send undefined opcodes to a
// sticky TRAP state; otherwise they retire as a NOP and illegal stays 0.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    control_fsm_if.slave bus
);
    state_e          state_q, state_d, dec_target;
    logic [3:0]      op_q;
    logic [OP_W-1:0] op_full;
    logic            op_hi_nz, wait_st, expired, timeout, clr, inc, go;

    assign op_full = bus.op;

    if (OP_W > 4) begin : g_op_hi
        assign op_hi_nz = |op_full[OP_W-1:4];
    end else begin : g_no_op_hi
        assign op_hi_nz = 1'b0;
    end

    assign dec_target = op_hi_nz ? StFetch : op_target(op_full[3:0]);
    assign go         = !bus.stall;
    assign wait_st    = state_q inside {StFetch, StMemRd, StMemWr};
    // A ready arriving on the expiry cycle still counts as success.
    assign timeout    = wait_st && expired && !bus.mem_ready && go;

    always_comb begin
        state_d = state_q;
        if (go) begin
            unique case (state_q)
                StFetch:   if (bus.mem_ready) state_d = StDecode;
                StDecode: begin
                    if (dec_target == StFetch) begin
`ifdef CONTROL_FSM_TRAP_EN
                        state_d = StTrap;
`else
                        state_d = StFetch;
`endif
                    end else begin
                        state_d = dec_target;
                    end
                end
                StExecR,
                StExecI:   state_d = StAluWb;
                StMemAddr: state_d = (op_q == OP_LOAD) ? StMemRd :
                                     (op_q == OP_STORE) ? StMemWr : StFetch;
                StMemRd: begin
                    if (bus.mem_ready) state_d = StMemWb;
                    else if (timeout)  state_d = StFetch;
                end
                StMemWr:   if (bus.mem_ready || timeout) state_d = StFetch;
                StMemWb,
                StAluWb,
                StBranch:  state_d = StFetch;
                StTrap:    state_d = StTrap;
                default:   state_d = StFetch;
            endcase
        end
    end

    // Clearing on every transition covers entry into each wait state, including FETCH re-entry.
    assign clr = go && ((state_d != state_q) || timeout);
    assign inc = wait_st && !bus.mem_ready && go;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (inc),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode && go) op_q <= op_full[3:0];
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src    = 1'b0;
        bus.result_src = 1'b0;
        bus.imm_src    = IMM_I;
        bus.branch     = 1'b0;
        bus.mem_err    = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.mem_err = timeout;
            unique case (state_q)
                StFetch: begin
                    bus.mem_read = go;
                    bus.ir_write = go && bus.mem_ready;
                    bus.pc_write = go && bus.mem_ready;
                end
                StExecR:   bus.imm_src = IMM_R;
                StExecI:   bus.alu_src = 1'b1;
                StAluWb: begin
                    bus.reg_write = go;
                    bus.imm_src   = (op_q <= OP_R_LAST) ? IMM_R : IMM_I;
                end
                StMemAddr: bus.imm_src = IMM_M;
                StMemRd:   bus.mem_read = go;
                StMemWb: begin
                    bus.reg_write  = go;
                    bus.result_src = 1'b1;
                end
                StMemWr:   bus.mem_write = go;
                StBranch: begin
                    bus.imm_src = IMM_M;
                    bus.branch  = op_q inside {OP_BEQ, OP_BNE};
                end
`ifdef CONTROL_FSM_TRAP_EN
                StTrap:    bus.illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; the undefined-opcode vectors follow CONTROL_FSM_TRAP_EN.
module tb_control_fsm;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_fsm_if #(.OP_W(4)) bus ();

    control_fsm #(
        .OP_W   (4),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, result_src,
    //  imm_src[1:0], branch, mem_err, illegal}
    logic [11:0] outs;
    assign outs = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                   bus.alu_src, bus.result_src, bus.imm_src, bus.branch, bus.mem_err,
                   bus.illegal};

    int unsigned total;
    int unsigned bad;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
        end
    endtask

    // Advance one edge, apply this cycle's inputs, then compare the decoded outputs.
    task automatic step(input logic rdy, input logic stl, input logic [3:0] opc, input logic r,
                        input string tag, input logic [11:0] exp);
        @(posedge clk);
        #2;
        bus.mem_ready = rdy;
        bus.stall     = stl;
        bus.op        = opc;
        rst           = r;
        #1;
        check(tag, outs, exp);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.stall     = 1'b0;
        bus.op        = 4'h0;

        step(1, 0, 4'h0, 1, "rst_hold", 12'h000);
        step(1, 0, 4'h0, 1, "rst_hold2", 12'h000);

        // R-type, immediate ready
        step(1, 0, 4'h3, 0, "r_fetch", 12'hD00);
        step(1, 0, 4'h3, 0, "r_decode", 12'h000);
        step(1, 0, 4'h0, 0, "r_exec", 12'h010);
        step(1, 0, 4'h0, 0, "r_wb", 12'h210);

        // Immediate type behind a slow fetch
        step(0, 0, 4'h7, 0, "i_fetch_wait", 12'h100);
        step(1, 0, 4'h7, 0, "i_fetch", 12'hD00);
        step(1, 0, 4'h7, 0, "i_decode", 12'h000);
        step(1, 0, 4'h0, 0, "i_exec", 12'h040);
        step(1, 0, 4'h0, 0, "i_wb", 12'h200);

        // Load with three wait cycles; op changes after DECODE to exercise the latch
        step(1, 0, 4'h9, 0, "ld_fetch", 12'hD00);
        step(1, 0, 4'h9, 0, "ld_decode", 12'h000);
        step(0, 0, 4'h0, 0, "ld_addr", 12'h008);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 0, "ld_wait", 12'h100);
        step(1, 0, 4'h0, 0, "ld_done", 12'h100);
        step(1, 0, 4'h0, 0, "ld_wb", 12'h220);

        // Store that never completes
        step(1, 0, 4'hA, 0, "st_fetch", 12'hD00);
        step(1, 0, 4'hA, 0, "st_decode", 12'h000);
        step(0, 0, 4'h0, 0, "st_addr", 12'h008);
        for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 0, "st_wait", 12'h080);
        step(0, 0, 4'h0, 0, "st_timeout", 12'h082);
        step(1, 0, 4'h0, 0, "st_refetch", 12'hD00);

        // Taken-branch type, then compare
        step(1, 0, 4'hC, 0, "beq_decode", 12'h000);
        step(1, 0, 4'h0, 0, "beq_branch", 12'h00C);
        step(1, 0, 4'hB, 0, "cmp_fetch", 12'hD00);
        step(1, 0, 4'hB, 0, "cmp_decode", 12'h000);
        step(1, 0, 4'h0, 0, "cmp_branch", 12'h008);

        // Load whose ready lands exactly on the expiry cycle
        step(1, 0, 4'h9, 0, "ldb_fetch", 12'hD00);
        step(1, 0, 4'h9, 0, "ldb_decode", 12'h000);
        step(0, 0, 4'h0, 0, "ldb_addr", 12'h008);
        for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 0, "ldb_wait", 12'h100);
        step(1, 0, 4'h0, 0, "ldb_edge", 12'h100);
        step(0, 0, 4'h0, 0, "ldb_wb", 12'h220);

        // Undefined opcode
        step(1, 0, 4'hF, 0, "und_fetch", 12'hD00);
        step(1, 0, 4'hF, 0, "und_decode", 12'h000);
`ifdef CONTROL_FSM_TRAP_EN
        step(1, 0, 4'h0, 0, "trap", 12'h001);
        step(1, 0, 4'h0, 0, "trap_hold", 12'h001);
        step(1, 0, 4'h0, 1, "trap_rst", 12'h000);
        step(1, 0, 4'h0, 0, "trap_exit", 12'hD00);
`else
        step(1, 0, 4'h0, 0, "und_nop", 12'hD00);
`endif

        // Stall while in MEM_WR; ready is ignored until stall drops
        step(1, 0, 4'hA, 0, "sst_decode", 12'h000);
        step(0, 0, 4'h0, 0, "sst_addr", 12'h008);
        step(1, 1, 4'h0, 0, "sst_stall", 12'h000);
        step(1, 1, 4'h0, 0, "sst_stall2", 12'h000);
        step(0, 0, 4'h0, 0, "sst_resume", 12'h080);
        step(1, 0, 4'h0, 0, "sst_done", 12'h080);

        // Reset in the middle of a load
        step(1, 0, 4'h9, 0, "rr_fetch", 12'hD00);
        step(1, 0, 4'h9, 0, "rr_decode", 12'h000);
        step(0, 0, 4'h0, 0, "rr_addr", 12'h008);
        step(0, 0, 4'h0, 0, "rr_wait", 12'h100);
        step(1, 0, 4'h0, 1, "rr_rst", 12'h000);
        step(1, 0, 4'h0, 0, "rr_after", 12'hD00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
